down_counter_timer: RTL and testbench

//   Loadable down-counter / countdown timer: the count-down counterpart of the
//   4-bit up-counter. Loaded with a start value, decrements once per enabled

---
 rtl/down_counter_timer.sv | 90 +++++++++
 tb/tb_down_counter_timer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// Loadable down-counter / countdown timer with a one-cycle done pulse at terminal count.
// Optional periodic reload at terminal count: define DOWN_COUNTER_TIMER_RELOAD_EN.
module down_counter_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_d;
  logic             done_d;
  logic             busy_d;
  logic             zero_d;

`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
  logic [WIDTH-1:0] reload_q;

  // Start value remembered for the periodic restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_q <= '0;
    end else if (load) begin
      reload_q <= load_val;
    end
  end
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count   <= '0;
      busy    <= 1'b0;
      zero    <= 1'b1;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      busy    <= busy_d;
      zero    <= zero_d;
      done    <= done_d;
    end
  end

  // Next state and next count: load beats decrement beats hold.
  always_comb begin
    state_d = state_q;
    count_d = count;
    done_d  = 1'b0;
    if (load) begin
      count_d = load_val;
      state_d = (load_val != '0) ? RUN : IDLE;
    end else if ((state_q == RUN) && en) begin
      if (count == WIDTH'(1)) begin
        done_d  = 1'b1;
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
        count_d = reload_q;
`else
        count_d = '0;
        state_d = IDLE;
`endif
      end else begin
        count_d = count - WIDTH'(1);
      end
    end
  end

  // Status flags follow the next state/count so they line up with the registered count.
  always_comb begin
    busy_d = 1'b0;
    zero_d = 1'b0;
    busy_d = (state_d == RUN);
    zero_d = (count_d == '0);
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: vector table, corner sequences, random vs model.
module tb_down_counter_timer;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             zero;
  logic             done;

  int tests;
  int fails;

  typedef struct {
    logic             load;
    logic [WIDTH-1:0] val;
    logic             en;
    logic [WIDTH-1:0] e_count;
    logic             e_busy;
    logic             e_zero;
    logic             e_done;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  int  m_count;
  bit  m_run;
  bit  m_done;
  int  m_reload;

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .count    (count),
    .busy     (busy),
    .zero     (zero),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] ec, input logic eb,
                       input logic ez, input logic ed);
    tests++;
    if (count !== ec || busy !== eb || zero !== ez || done !== ed) begin
      fails++;
      $display("FAIL %s: got count=%0d busy=%b zero=%b done=%b, expected count=%0d busy=%b zero=%b done=%b",
               name, count, busy, zero, done, ec, eb, ez, ed);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic l, input int v, input logic e, input int c,
                     input logic b, input logic z, input logic d);
    vec_t x;
    x.load = l; x.val = WIDTH'(v); x.en = e;
    x.e_count = WIDTH'(c); x.e_busy = b; x.e_zero = z; x.e_done = d;
    vecs.push_back(x);
  endtask

  // Behavioural rule set: one call per clock edge.
  task automatic model_step(input bit l, input int v, input bit e);
    if (l) begin
      m_count  = v;
      m_run    = (v != 0);
      m_done   = 0;
      m_reload = v;
    end else if (m_run && e) begin
      if (m_count == 1) begin
        m_done = 1;
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
        m_count = m_reload;
`else
        m_count = 0;
        m_run   = 0;
`endif
      end else begin
        m_count = m_count - 1;
        m_done  = 0;
      end
    end else begin
      m_done = 0;
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_run = 0; m_done = 0; m_reload = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    tests = 0;
    fails = 0;
    rst = 1'b0; load = 1'b0; load_val = '0; en = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 4'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;

`ifndef DOWN_COUNTER_TIMER_RELOAD_EN
    // Countdown from 5
    add(1, 5, 0, 5, 1, 0, 0);
    add(0, 0, 1, 4, 1, 0, 0);
    add(0, 0, 1, 3, 1, 0, 0);
    add(0, 0, 1, 2, 1, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 1, 0);
    // Pause with en toggling
    add(1, 3, 0, 3, 1, 0, 0);
    add(0, 0, 1, 2, 1, 0, 0);
    add(0, 0, 0, 2, 1, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0);
    // Reload at terminal suppresses done, then load 0 returns to idle
    add(1, 2, 0, 2, 1, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0);
    add(1, 9, 1, 9, 1, 0, 0);
    add(0, 0, 1, 8, 1, 0, 0);
    add(1, 0, 1, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 1, 0);
    add(1, 15, 0, 15, 1, 0, 0);
    add(0, 0, 0, 15, 1, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      load = vecs[i].load; load_val = vecs[i].val; en = vecs[i].en;
      tick();
      check($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_busy, vecs[i].e_zero, vecs[i].e_done);
    end
    load = 1'b0; en = 1'b0;
`else
    // Periodic reload: load 4 then 12 enabled cycles
    @(negedge clk);
    load = 1'b1; load_val = 4'd4; en = 1'b0;
    tick();
    check("reload_load", 4'd4, 1'b1, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) n++;
      check($sformatf("reload_cyc%0d", i), WIDTH'(4 - ((i + 1) % 4)), 1'b1, 1'b0,
            ((i + 1) % 4) == 0);
    end
    check_int("reload_pulses", n, 3);
    en = 1'b0;
`endif

    // Async reset mid-countdown from 7
    do_reset();
    load = 1'b1; load_val = 4'd7; en = 1'b0;
    tick();
    load = 1'b0;
    check("pre_abort", 4'd7, 1'b1, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    check("async_abort", 4'd0, 1'b0, 1'b1, 1'b0);
    #1;
    rst = 1'b1;

    // Load 0, then idle enable must not wrap
    @(negedge clk);
    load = 1'b1; load_val = '0; en = 1'b0;
    tick();
    check("load_zero", 4'd0, 1'b0, 1'b1, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("idle_en%0d", i), 4'd0, 1'b0, 1'b1, 1'b0);
    end

    // Load 15: done after exactly 15 enabled cycles (bounded wait)
    load = 1'b1; load_val = 4'd15; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check_int("latency15", n, 15);
    en = 1'b0;

    // Random stimulus against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit l;
      bit e;
      int v;
      @(negedge clk);
      l = ($urandom_range(0, 9) == 0);
      v = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
      e = ($urandom_range(0, 3) != 0);
      load = l; load_val = WIDTH'(v); en = e;
      model_step(l, v, e);
      tick();
      check($sformatf("rand%0d", i), WIDTH'(m_count), m_run, m_count == 0, m_done);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
